// File: rtl/display_scan_controller_if.sv
// -----------------------------------------------------------------------------
// display_scan_controller_if
//
// Bundles the display-word handshake and the scan outputs of
// display_scan_controller so the controller and whoever sits around it share
// one connection object.
//
//   run          master -> slave  1 = scanning enabled, 0 = display dark
//   data_in      master -> slave  16-bit display word, [15:12] leftmost digit
//   data_valid   master -> slave  data_in valid this cycle
//   data_ready   slave -> master  pending buffer empty
//   scan_sel     slave -> master  2-bit digit select for the 1:4 demux
//   scan_e       slave -> master  demux enable, 1 = selected digit lit
//   digit_nibble slave -> master  value of the currently selected digit
//   frame_start  slave -> master  one-cycle pulse on the first cycle of slot 0
// -----------------------------------------------------------------------------
interface display_scan_controller_if;
  logic        run;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [1:0]  scan_sel;
  logic        scan_e;
  logic [3:0]  digit_nibble;
  logic        frame_start;

  // Upstream side: supplies words and the run control, observes the scan.
  modport master (
    output run, data_in, data_valid,
    input  data_ready, scan_sel, scan_e, digit_nibble, frame_start
  );

  // Controller side.
  modport slave (
    input  run, data_in, data_valid,
    output data_ready, scan_sel, scan_e, digit_nibble, frame_start
  );
endinterface : display_scan_controller_if

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Time-multiplexes a 4-digit display. Each digit owns a slot of DIVIDE clock
// cycles: the first BLANK cycles are dark (anti-ghosting gap while the demux
// select settles), the rest are lit. A new display word is accepted through a
// valid/ready handshake into a pending buffer and only copied into the shadow
// (displayed) word at a frame boundary, so a frame never shows a mix of words.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    display_scan_controller_if.slave
//            run, data_in, data_valid            (inputs)
//            data_ready, scan_sel, scan_e,
//            digit_nibble, frame_start           (outputs)
//
// Parameters:
//   DIV_WIDTH  width of the slot counter
//   DIVIDE     cycles per digit slot, 2 .. 2**DIV_WIDTH-1
//   BLANK      dark cycles at the start of each slot, 1 .. DIVIDE-1
// -----------------------------------------------------------------------------
module display_scan_controller #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIVIDE    = 50000,
  parameter int unsigned BLANK     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  display_scan_controller_if.slave    bus
);

  localparam logic [DIV_WIDTH-1:0] CNT_LAST  = DIV_WIDTH'(DIVIDE - 1);
  localparam logic [DIV_WIDTH-1:0] CNT_BLANK = DIV_WIDTH'(BLANK);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,  state_d;
  logic [DIV_WIDTH-1:0]   cnt_q,    cnt_d;
  logic [1:0]             sel_q,    sel_d;
  logic                   en_q,     en_d;
  logic                   fs_q,     fs_d;
  logic [15:0]            shadow_q, shadow_d;
  logic [15:0]            pend_q,   pend_d;
  logic                   full_q,   full_d;

  logic                   boundary;
  logic                   transfer;

  assign transfer = bus.data_valid && !full_q;

  // ---------------------------------------------------------------------------
  // Next-state logic: scan sequencing and double buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    fs_d     = 1'b0;
    boundary = 1'b0;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    full_d   = full_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        sel_d = 2'b00;
        if (bus.run) begin
          // Starting a scan is itself a frame boundary.
          state_d  = ST_SCAN;
          fs_d     = 1'b1;
          boundary = 1'b1;
        end
      end

      ST_SCAN: begin
        if (!bus.run) begin
          // Stop immediately, even mid-slot; buffers are kept.
          state_d = ST_IDLE;
          cnt_d   = '0;
          sel_d   = 2'b00;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sel_d = sel_q + 2'd1;
          if (sel_q == 2'b11) begin
            fs_d     = 1'b1;
            boundary = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Enable is derived from the next counter value so the registered scan_e
    // lines up with the registered counter. A new slot always starts at 0 and
    // BLANK >= 1, so the select never changes while a digit is lit.
    en_d = (state_d == ST_SCAN) && (cnt_d >= CNT_BLANK);

    // Boundary load uses the pending word held before this edge; a transfer on
    // the same edge only fills pending (it can only happen when pending was
    // empty, so the two never compete for the same word).
    if (boundary && full_q) begin
      shadow_d = pend_q;
      full_d   = 1'b0;
    end
    if (transfer) begin
      pend_d = bus.data_in;
      full_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
      en_q     <= 1'b0;
      fs_q     <= 1'b0;
      shadow_q <= 16'h0000;
      pend_q   <= 16'h0000;
      full_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      fs_q     <= fs_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      full_q   <= full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers, or combinational only from sel_q and shadow_q
  // ---------------------------------------------------------------------------
  logic [3:0] nibble;

  // Select 00 drives the leftmost digit, matching the demux strobe order.
  always_comb begin
    nibble = shadow_q[15:12];
    unique case (sel_q)
      2'b00: nibble = shadow_q[15:12];
      2'b01: nibble = shadow_q[11:8];
      2'b10: nibble = shadow_q[7:4];
      2'b11: nibble = shadow_q[3:0];
      default: nibble = shadow_q[15:12];
    endcase
  end

  assign bus.data_ready   = !full_q;
  assign bus.scan_sel     = sel_q;
  assign bus.scan_e       = en_q;
  assign bus.frame_start  = fs_q;
  assign bus.digit_nibble = nibble;

endmodule : display_scan_controller

// File: tb/tb_display_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_display_scan_controller
//
// Directed sequence followed by a random phase. A behavioural model tracks
// the time since scanning began and derives slot, select, enable and frame
// pulse from it arithmetically; a small pending/shadow model follows the
// handshake and frame-boundary rules. All outputs are compared every cycle,
// one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_display_scan_controller;

  localparam int D     = 8;
  localparam int B     = 2;
  localparam int FRAME = 4 * D;

  logic clk;
  logic reset;

  display_scan_controller_if bus ();

  display_scan_controller #(
    .DIV_WIDTH (16),
    .DIVIDE    (D),
    .BLANK     (B)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit          m_scan;   // scanning
  int          m_t;      // cycles since the scan started (0 = start edge)
  logic [15:0] m_shadow;
  logic [15:0] m_pend;
  bit          m_full;
  bit          m_fs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_scan   = 0;
    m_t      = 0;
    m_shadow = 16'h0000;
    m_pend   = 16'h0000;
    m_full   = 0;
    m_fs     = 0;
  endtask

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge(input bit run, input bit dv, input logic [15:0] din);
    bit boundary;
    bit xfer;
    boundary = 0;
    xfer     = dv && !m_full;
    if (!m_scan) begin
      if (run) begin
        m_scan   = 1;
        m_t      = 0;
        boundary = 1;
      end
    end else if (!run) begin
      m_scan = 0;
      m_t    = 0;
    end else begin
      m_t++;
      boundary = (m_t % FRAME) == 0;
    end
    m_fs = boundary;
    if (boundary && m_full) begin
      m_shadow = m_pend;
      m_full   = 0;
    end
    if (xfer) begin
      m_pend = din;
      m_full = 1;
    end
  endtask

  task automatic check_outputs();
    int          sel;
    bit          en;
    logic [3:0]  nib;
    sel = m_scan ? (m_t / D) % 4 : 0;
    en  = m_scan && ((m_t % D) >= B);
    nib = 4'((m_shadow >> (4 * (3 - sel))) & 16'hF);
    check("scan_sel",     32'(bus.scan_sel),     32'(sel));
    check("scan_e",       32'(bus.scan_e),       32'(en));
    check("frame_start",  32'(bus.frame_start),  32'(m_fs));
    check("digit_nibble", 32'(bus.digit_nibble), 32'(nib));
    check("data_ready",   32'(bus.data_ready),   32'(!m_full));
  endtask

  // One clock: sample inputs at the edge into the model, then compare.
  task automatic tick();
    bit          run_s;
    bit          dv_s;
    logic [15:0] din_s;
    @(posedge clk);
    run_s = bus.run;
    dv_s  = bus.data_valid;
    din_s = bus.data_in;
    if (reset) model_reset();
    else       model_edge(run_s, dv_s, din_s);
    #1;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model is scanning at the given position in the frame.
  task automatic wait_phase(input int phase);
    bit hit;
    hit = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (m_scan && (m_t % FRAME) == phase) begin
        hit = 1;
        break;
      end
      tick();
    end
    check("wait_phase_reached", 32'(hit), 32'd1);
  endtask

  task automatic send_one(input logic [15:0] w);
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    tick();
    bus.data_valid = 1'b0;
  endtask

  initial begin
    bus.run        = 1'b0;
    bus.data_in    = 16'h0000;
    bus.data_valid = 1'b0;
    reset          = 1'b1;
    model_reset();

    // Reset state.
    ticks(2);
    #2 reset = 1'b0;

    // Free-running scan with no data: digits all zero.
    bus.run = 1'b1;
    ticks(2 * FRAME + 4);

    // Load 0x1234 while idle, then start.
    bus.run = 1'b0;
    ticks(3);
    send_one(16'h1234);
    check("ready_low_after_idle_load", 32'(bus.data_ready), 32'd0);
    ticks(2);
    bus.run = 1'b1;
    tick();
    check("shadow_at_start_digit0", 32'(bus.digit_nibble), 32'h1);
    ticks(FRAME + 2);

    // Transfer in slot 01; a second word must be refused until the boundary.
    wait_phase(D + 3);
    send_one(16'hABCD);
    bus.data_in    = 16'h5555;
    bus.data_valid = 1'b1;
    ticks(6);
    bus.data_valid = 1'b0;
    wait_phase(0);
    check("abcd_at_next_frame", 32'(bus.digit_nibble), 32'hA);
    ticks(FRAME);

    // Transfer on the exact wrap edge with pending empty.
    wait_phase(FRAME - 1);
    send_one(16'h9876);
    check("wrap_keeps_old_shadow", 32'(bus.digit_nibble), 32'hA);
    ticks(2 * FRAME);

    // Drop run at counter 4 of slot 10, then restart.
    wait_phase(2 * D + 4);
    bus.run = 1'b0;
    tick();
    check("stop_sel_zero", 32'(bus.scan_sel), 32'd0);
    ticks(3);
    bus.run = 1'b1;
    ticks(D + 2);

    // Shadow 0x1234 with pending full, then async reset while lit.
    wait_phase(FRAME - 3);
    send_one(16'h1234);
    wait_phase(3);
    send_one(16'h4321);
    ticks(2);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("async_ready", 32'(bus.data_ready), 32'd1);
    #2 reset = 1'b0;
    ticks(FRAME + 3);

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      bus.run        = ($urandom_range(0, 19) != 0);
      bus.data_valid = ($urandom_range(0, 3) == 0);
      bus.data_in    = 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_display_scan_controller
